mux5_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one 5:1 mux (mux5) among five requesters.

---
 rtl/mux5_rr_sched_if.sv | 32 +++
 rtl/mux5_rr_sched.sv | 133 +++++++++++++
 tb/tb_mux5_rr_sched.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mux5_rr_sched_if.sv
// rtl/mux5_rr_sched_if.sv - request/grant bundle between requesters and the mux5 scheduler
// Purpose: groups the arbitration handshake of mux5_rr_sched.
//   req      : per-source request, driven by the requesters (master)
//   gnt      : one-hot grant, driven by the scheduler (slave)
//   sel      : mux5 select, 0..4 = owner, 5 = idle
//   busy     : 1 while any grant is active
//   hold_cnt : cycles the current owner has held the mux
interface mux5_rr_sched_if #(
  parameter int CNT_W = 4
);
  logic [4:0]       req;
  logic [4:0]       gnt;
  logic [2:0]       sel;
  logic             busy;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  busy,
    input  hold_cnt
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output busy,
    output hold_cnt
  );
endinterface

// File: rtl/mux5_rr_sched.sv
// rtl/mux5_rr_sched.sv - round-robin scheduler driving the select of a shared 5:1 mux
// Purpose: decides each cycle which of five requesters owns mux5, bounds each
// tenure to MAX_HOLD cycles and rotates priority so nobody starves.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of mux5_rr_sched_if (req in; gnt/sel/busy/hold_cnt out)
// All outputs come straight from flops.
module mux5_rr_sched #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  mux5_rr_sched_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [2:0]       SEL_IDLE  = 3'd5;
  localparam logic [2:0]       LAST_INIT = 3'd4;
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [4:0]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [2:0]       last_q, last_d;

  logic [2:0]       search_base;
  logic [2:0]       win;
  logic             own_req;
  logic             do_grant;
  logic             do_idle;

  // First set request scanning base+1, base+2, ... modulo 5. The base itself
  // is visited last, so a lone preempted owner is re-granted naturally.
  function automatic logic [2:0] pick_winner(input logic [4:0] r, input logic [2:0] base);
    logic [2:0] idx;
    logic [2:0] w;
    logic       found;
    w     = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      idx = 3'((int'(base) + k) % 5);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // In GRANT the current owner becomes the new rotation pointer whenever the
  // tenure ends, so the search is based on it rather than on last_q.
  assign search_base = (state_q == GRANT) ? sel_q : last_q;
  assign win         = pick_winner(bus.req, search_base);
  assign own_req     = |(bus.req & gnt_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    hold_d   = hold_q;
    last_d   = last_q;
    do_grant = 1'b0;
    do_idle  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req) do_grant = 1'b1;
      end
      GRANT: begin
        if (!own_req) begin
          last_d = sel_q;
          if (|bus.req) do_grant = 1'b1;
          else          do_idle  = 1'b1;
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end else begin
          // Tenure exhausted: owner's own request is still set, so a winner exists.
          last_d   = sel_q;
          do_grant = 1'b1;
        end
      end
      default: do_idle = 1'b1;
    endcase

    if (do_grant) begin
      state_d = GRANT;
      gnt_d   = 5'b00001 << win;
      sel_d   = win;
      busy_d  = 1'b1;
      hold_d  = HOLD_ONE;
    end else if (do_idle) begin
      state_d = IDLE;
      gnt_d   = 5'b00000;
      sel_d   = SEL_IDLE;
      busy_d  = 1'b0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 5'b00000;
      sel_q   <= SEL_IDLE;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      last_q  <= LAST_INIT;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.hold_cnt = hold_q;

endmodule

// File: tb/tb_mux5_rr_sched.sv
// tb/tb_mux5_rr_sched.sv - self-checking bench for mux5_rr_sched
module tb_mux5_rr_sched;

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic [4:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic [3:0] hold;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  vec_t vecs[$];
  vec_t sb[$];
  vec_t e;
  logic [4:0] mux_d;
  logic       mux_y;

  mux5_rr_sched_if #(.CNT_W(4)) bus ();

  mux5_rr_sched #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference mux5 model fed by the scheduler's select.
  always_comb begin
    mux_y = 1'b0;
    if (bus.sel < 3'd5) mux_y = mux_d[bus.sel];
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input vec_t x);
    chk({tag, " gnt"},  {3'b0, bus.gnt},      {3'b0, x.gnt});
    chk({tag, " sel"},  {5'b0, bus.sel},      {5'b0, x.sel});
    chk({tag, " busy"}, {7'b0, bus.busy},     {7'b0, x.busy});
    chk({tag, " hold"}, {4'b0, bus.hold_cnt}, {4'b0, x.hold});
  endtask

  function automatic vec_t mk(input logic [4:0] r, input logic [4:0] g, input logic [2:0] s,
                              input logic b, input logic [3:0] h);
    vec_t v;
    v = '{rst: 1'b0, req: r, gnt: g, sel: s, busy: b, hold: h};
    return v;
  endfunction

  function automatic vec_t mk_idle(input logic [4:0] r);
    return mk(r, 5'b00000, 3'd5, 1'b0, 4'd0);
  endfunction

  function automatic vec_t mk_rst();
    vec_t v;
    v = mk_idle(5'b00000);
    v.rst = 1'b1;
    return v;
  endfunction

  // Called at a negedge; leaves reset released at a negedge with req cleared.
  task automatic do_reset(input string tag);
    vec_t r;
    r = mk_idle(5'b11111);
    reset_n = 1'b0;
    bus.req = 5'b11111;
    #1;
    chk_out({tag, " rst_async"}, r);
    @(negedge clk);
    chk_out({tag, " rst_held"}, r);
    reset_n = 1'b1;
    bus.req = 5'b00000;
  endtask

  task automatic step(input string tag, input vec_t v);
    bus.req = v.req;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk_out(tag, e);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    bus.req = 5'b00000;
    mux_d   = 5'b00000;

    // Single request, release to idle, then pointer-based priority after owner 2.
    vecs.push_back(mk_rst());
    vecs.push_back(mk(5'b00100, 5'b00100, 3'd2, 1'b1, 4'd1));
    vecs.push_back(mk_idle(5'b00000));
    vecs.push_back(mk(5'b00011, 5'b00001, 3'd0, 1'b1, 4'd1));
    vecs.push_back(mk(5'b00010, 5'b00010, 3'd1, 1'b1, 4'd1));
    vecs.push_back(mk_idle(5'b00000));
    // Rotation between 0 and 4 with wrap.
    vecs.push_back(mk_rst());
    for (int i = 0; i < 4; i++) vecs.push_back(mk(5'b10001, 5'b00001, 3'd0, 1'b1, 4'(i + 1)));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(5'b10001, 5'b10000, 3'd4, 1'b1, 4'(i + 1)));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(5'b10001, 5'b00001, 3'd0, 1'b1, 4'(i + 1)));
    vecs.push_back(mk_idle(5'b00000));
    // Lone hog re-granted after each full tenure.
    vecs.push_back(mk_rst());
    for (int i = 0; i < 10; i++) vecs.push_back(mk(5'b01000, 5'b01000, 3'd3, 1'b1, 4'((i % 4) + 1)));
    vecs.push_back(mk_idle(5'b00000));
    // Competitor arrives mid-tenure; preempted at the hold limit.
    vecs.push_back(mk_rst());
    vecs.push_back(mk(5'b00001, 5'b00001, 3'd0, 1'b1, 4'd1));
    vecs.push_back(mk(5'b00001, 5'b00001, 3'd0, 1'b1, 4'd2));
    vecs.push_back(mk(5'b00011, 5'b00001, 3'd0, 1'b1, 4'd3));
    vecs.push_back(mk(5'b00011, 5'b00001, 3'd0, 1'b1, 4'd4));
    vecs.push_back(mk(5'b00011, 5'b00010, 3'd1, 1'b1, 4'd1));
    vecs.push_back(mk(5'b00011, 5'b00010, 3'd1, 1'b1, 4'd2));
    vecs.push_back(mk_idle(5'b00000));

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset($sformatf("vec%0d", i));
      else             step($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back handoff from owner 1 to owner 3 with mux data check.
    do_reset("b2b");
    mux_d = 5'b01000;
    step("b2b own1", mk(5'b00010, 5'b00010, 3'd1, 1'b1, 4'd1));
    step("b2b own1 pend3", mk(5'b01010, 5'b00010, 3'd1, 1'b1, 4'd2));
    step("b2b handoff", mk(5'b01000, 5'b01000, 3'd3, 1'b1, 4'd1));
    chk("b2b mux_y", {7'b0, mux_y}, 8'd1);
    step("b2b idle", mk_idle(5'b00000));
    chk("b2b mux_y idle", {7'b0, mux_y}, 8'd0);

    // Asynchronous reset between clock edges while source 2 owns the mux.
    do_reset("async");
    step("async own2", mk(5'b00100, 5'b00100, 3'd2, 1'b1, 4'd1));
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async drop", mk_idle(5'b00000));
    bus.req = 5'b11111;
    @(negedge clk);
    chk_out("async held", mk_idle(5'b11111));
    reset_n = 1'b1;
    step("async restart", mk(5'b11111, 5'b00001, 3'd0, 1'b1, 4'd1));
    step("async release0", mk(5'b11110, 5'b00010, 3'd1, 1'b1, 4'd1));
    step("async idle", mk_idle(5'b00000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
